intc: RTL and testbench

INTC -- requirements
Module: intc

---
 rtl/intc_pkg.sv | 10 +
 rtl/intc_prio.sv | 15 +
 rtl/intc.sv | 70 +++++++
 tb/tb_intc.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// intc_pkg: register map, source count and source-id type shared by the interrupt controller.
package intc_pkg;
    localparam int NSRC = 4;
    localparam int ADDR_WIDTH = 16;
    localparam logic [15:0] A_PEND = 16'h000a;
    localparam logic [15:0] A_EN = 16'h000c;
    localparam logic [15:0] A_MODE = 16'h000e;
    localparam logic [15:0] A_VEC = 16'h0010;
    typedef logic [3:0] src_id_t;
endpackage

// File: rtl/intc_prio.sv
// intc_prio: find-first-set, lowest index wins.
module intc_prio import intc_pkg::*; #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output src_id_t      id
);
    always_comb begin
        valid = |req;
        id = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[i]) id = src_id_t'(i);
    end
endmodule

// File: rtl/intc.sv
// intc: prioritised interrupt controller with edge/level sources, claim via VEC read and EOI via VEC write.
module intc import intc_pkg::*; #(
    parameter int NSRC = intc_pkg::NSRC,
    parameter int ADDR_WIDTH = intc_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  wr_mem,
    input  logic                  byt,
    input  logic [15:0]           wr_data,
    output logic [15:0]           rd_data,
    output logic                  rd_sel,
    input  logic [NSRC-1:0]       src_irq,
    output logic                  irq
);
    logic [NSRC-1:0] s_q, s_d, pend, insv, pend_n, insv_n, set, clr, edge_m;
    logic [15:0] en, mode, bm, wd_m, rd_n;
    logic [ADDR_WIDTH-2:0] wa;
    logic sel_pend, sel_en, sel_mode, sel_vec, claim, eoi, win_v, svc_v, irq_n;
    src_id_t win_id, svc_id;

    intc_prio #(.N(NSRC)) u_win (.req(pend & en[NSRC-1:0]), .valid(win_v), .id(win_id));
    intc_prio #(.N(NSRC)) u_svc (.req(insv), .valid(svc_v), .id(svc_id));

    always_comb begin
        wa = mem_addr[ADDR_WIDTH-1:1];
        sel_pend = wa == (ADDR_WIDTH-1)'(A_PEND >> 1);
        sel_en = wa == (ADDR_WIDTH-1)'(A_EN >> 1);
        sel_mode = wa == (ADDR_WIDTH-1)'(A_MODE >> 1);
        sel_vec = wa == (ADDR_WIDTH-1)'(A_VEC >> 1);
        bm = byt ? (mem_addr[0] ? 16'hff00 : 16'h00ff) : 16'hffff;
        wd_m = wr_data & bm;
        claim = sel_vec && !wr_mem && win_v;
        eoi = sel_vec && wr_mem;
        edge_m = mode[NSRC-1:0];
        set = s_q & ~s_d;
        clr = (wr_mem && sel_pend ? wd_m[NSRC-1:0] : '0) | (claim ? NSRC'(1) << win_id : '0);
        // set wins over any clear landing in the same cycle
        pend_n = (edge_m & ((pend & ~clr) | set)) | (~edge_m & s_q);
        insv_n = (insv | (claim ? NSRC'(1) << win_id : '0)) & ~(eoi && svc_v ? NSRC'(1) << svc_id : '0);
        rd_n = sel_pend ? 16'(pend) : sel_en ? en : sel_mode ? mode :
               sel_vec && win_v ? {1'b1, 11'd0, win_id} : 16'h0000;
        irq_n = win_v && (!svc_v || win_id < svc_id);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_q <= '0;
            s_d <= '0;
            pend <= '0;
            insv <= '0;
            en <= '0;
            mode <= '0;
            rd_data <= '0;
            rd_sel <= 1'b0;
            irq <= 1'b0;
        end else begin
            s_q <= src_irq;
            s_d <= s_q;
            pend <= pend_n;
            insv <= insv_n;
            en <= wr_mem && sel_en ? (en & ~bm) | wd_m : en;
            mode <= wr_mem && sel_mode ? (mode & ~bm) | wd_m : mode;
            rd_data <= wr_mem ? 16'h0000 : rd_n;
            rd_sel <= !wr_mem && (sel_pend || sel_en || sel_mode || sel_vec);
            irq <= irq_n;
        end
    end
endmodule

// File: tb/tb_intc.sv
// tb_intc: directed scenarios with a read-data scoreboard checked by an independent monitor.
module tb_intc;
    import intc_pkg::*;

    typedef struct {
        logic [15:0] d;
        int c;
    } exp_t;

    logic clk = 0, rst = 1, wr_mem = 0, byt = 0, rd_sel, irq;
    logic [15:0] mem_addr = 0, wr_data = 0, rd_data;
    logic [3:0] src_irq = 0;
    int checks = 0, errors = 0, cyc_n = 0;
    exp_t q[$];

    intc dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .wr_mem(wr_mem), .byt(byt),
        .wr_data(wr_data), .rd_data(rd_data), .rd_sel(rd_sel), .src_irq(src_irq), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    always @(negedge clk) begin
        if (q.size() != 0 && q[0].c <= cyc_n) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (rd_sel !== 1'b1 || rd_data !== e.d || e.c != cyc_n) begin
                errors++;
                $display("FAIL read cycle %0d: rd_sel=%b rd_data=%h expected rd_sel=1 rd_data=%h at cycle %0d",
                         cyc_n, rd_sel, rd_data, e.d, e.c);
            end
        end else begin
            checks++;
            if (rd_sel !== 1'b0) begin
                errors++;
                $display("FAIL rd_sel_idle cycle %0d: rd_sel=%b expected 0", cyc_n, rd_sel);
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [15:0] a, logic [15:0] d, logic b = 0);
        mem_addr = a; wr_data = d; byt = b; wr_mem = 1;
        tick();
        wr_mem = 0; byt = 0; mem_addr = 0;
    endtask

    task automatic rd(logic [15:0] a, logic [15:0] e);
        mem_addr = a;
        q.push_back('{e, cyc_n + 1});
        tick();
        mem_addr = 0;
    endtask

    task automatic chk(string n, logic [15:0] a, logic [15:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic chk_irq(logic e);
        @(negedge clk);
        chk("irq", 16'(irq), 16'(e));
    endtask

    task automatic pulse(logic [3:0] m);
        src_irq = src_irq | m;
        tick();
        src_irq = src_irq & ~m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick(2);
        chk_irq(0);
        chk("rst_rd_data", rd_data, 16'h0000);
        rst = 0;
        rd(A_PEND, 16'h0000);
        rd(A_EN, 16'h0000);
        rd(A_MODE, 16'h0000);
        rd(A_VEC, 16'h0000);
        rd(16'h0020, 16'h0000);
        q.pop_back();
        // single edge pulse: pend, irq, claim
        wr(A_EN, 16'h0001);
        wr(A_MODE, 16'h0001);
        pulse(4'b0001);
        tick(1);
        rd(A_PEND, 16'h0001);
        chk_irq(1);
        rd(A_VEC, 16'h8000);
        tick(1);
        chk_irq(0);
        rd(A_PEND, 16'h0000);
        wr(A_VEC, 16'h0000);
        // nested priority and EOI
        wr(A_EN, 16'h000f);
        wr(A_MODE, 16'h000f);
        pulse(4'b0100);
        tick(1);
        pulse(4'b0001);
        tick(2);
        rd(A_PEND, 16'h0005);
        rd(A_VEC, 16'h8000);
        tick(2);
        chk_irq(0);
        rd(A_PEND, 16'h0004);
        wr(A_VEC, 16'h0000);
        tick(1);
        chk_irq(1);
        rd(A_VEC, 16'h8002);
        tick(2);
        chk_irq(0);
        wr(A_VEC, 16'h0000);
        // level source ignores W1C and tracks input with two-cycle lag
        wr(A_MODE, 16'h000d);
        src_irq = 4'b0010;
        tick(3);
        rd(A_PEND, 16'h0002);
        wr(A_PEND, 16'h0002);
        tick(1);
        rd(A_PEND, 16'h0002);
        src_irq = 4'b0000;
        rd(A_PEND, 16'h0002);
        rd(A_PEND, 16'h0002);
        rd(A_PEND, 16'h0000);
        tick(2);
        chk_irq(0);
        // byte lanes
        wr(16'h000d, 16'h0f00, 1);
        rd(A_EN, 16'h0f0f);
        wr(16'h000c, 16'haa01, 1);
        rd(A_EN, 16'h0f01);
        wr(A_EN, 16'h000f);
        // edge set coincident with W1C
        src_irq = 4'b1000;
        tick();
        wr(A_PEND, 16'h0008);
        src_irq = 4'b0000;
        rd(A_PEND, 16'h0008);
        chk_irq(1);
        wr(A_EN, 16'h0007);
        tick(1);
        chk_irq(0);
        rd(A_PEND, 16'h0008);
        wr(A_PEND, 16'h0008);
        rd(A_PEND, 16'h0000);
        wr(A_EN, 16'h000f);
        // reset during service
        pulse(4'b0001);
        tick(2);
        rd(A_VEC, 16'h8000);
        rst = 1;
        tick(1);
        rst = 0;
        chk_irq(0);
        chk("rst2_rd_data", rd_data, 16'h0000);
        rd(A_EN, 16'h0000);
        rd(A_MODE, 16'h0000);
        rd(A_PEND, 16'h0000);
        wr(A_EN, 16'h0001);
        wr(A_MODE, 16'h0001);
        pulse(4'b0001);
        tick(2);
        chk_irq(1);
        rd(A_VEC, 16'h8000);
        wr(A_VEC, 16'h0000);
        tick(3);
        chk("scoreboard_drain", 16'(q.size()), 16'h0000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
